// File: rtl/masked_sbox_pkg.sv
// Shared types and defaults for the masked S-box sequencer and its datapath wrapper.
package masked_sbox_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int NBYTES_DEF = 16;
   localparam int LAT_DEF    = 2;
   localparam int RND_W_DEF  = 18;
   localparam int IDX_W      = $clog2(NBYTES_DEF);

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/masked_sbox_seq_if.sv
// PRNG handshake and S-box datapath bus; master is the sequencer side.
interface masked_sbox_seq_if
   import masked_sbox_pkg::*;
#(
   parameter int RND_W = RND_W_DEF
) ();

   logic             rnd_valid;
   logic             rnd_ready;
   logic [RND_W-1:0] rnd_data;
   logic             sb_vld;
   logic [7:0]       sb_a;
   logic [7:0]       sb_m;
   logic [RND_W-1:0] sb_rnd;
   logic [7:0]       sb_ra;
   logic [7:0]       sb_rm;

   modport master (
      input  rnd_valid, rnd_data, sb_ra, sb_rm,
      output rnd_ready, sb_vld, sb_a, sb_m, sb_rnd
   );

   modport slave (
      output rnd_valid, rnd_data, sb_ra, sb_rm,
      input  rnd_ready, sb_vld, sb_a, sb_m, sb_rnd
   );

endinterface

// File: rtl/masked_sbox_vpipe.sv
// LAT-deep valid+index shift pipeline tracking bytes in flight through the S-box datapath.
module masked_sbox_vpipe #(
   parameter int LAT = 2,
   parameter int IW  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [IW-1:0] idx_i,
   output logic          wb_vld_o,
   output logic [IW-1:0] wb_idx_o,
   output logic          empty_o
);

   logic [LAT:1]         vld_pipe_q;
   logic [LAT:1][IW-1:0] idx_pipe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         idx_pipe_q <= '0;
      end else begin
         vld_pipe_q[1] <= push_i;
         idx_pipe_q[1] <= idx_i;
         for (int k = 2; k <= LAT; k++) begin
            vld_pipe_q[k] <= vld_pipe_q[k-1];
            idx_pipe_q[k] <= idx_pipe_q[k-1];
         end
      end
   end

   assign wb_vld_o = vld_pipe_q[LAT];
   assign wb_idx_o = idx_pipe_q[LAT];

   // Stage LAT retires this cycle, so only earlier stages keep the pipe busy.
   always_comb begin
      empty_o = 1'b1;
      for (int k = 1; k < LAT; k++) begin
         if (vld_pipe_q[k]) empty_o = 1'b0;
      end
   end

endmodule

// File: rtl/masked_sbox_seq.sv
// Time-shares one two-share masked S-box datapath across an NBYTES-byte state.
// Optional MASKED_SBOX_SEQ_ZEROIZE_EN: idle datapath inputs forced to 0, buffers wiped after done.
module masked_sbox_seq
   import masked_sbox_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEF,
   parameter int LAT    = LAT_DEF,
   parameter int RND_W  = RND_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [8*NBYTES-1:0] st_in_a,
   input  logic [8*NBYTES-1:0] st_in_m,
   output logic [8*NBYTES-1:0] st_out_a,
   output logic [8*NBYTES-1:0] st_out_m,
   output logic                busy,
   output logic                done,
   masked_sbox_seq_if.master   sbif
);

   localparam int IW = idx_w(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   state_e                   state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [NBYTES-1:0][7:0]   bufa_q, bufm_q;
   logic                     issue;
   logic                     wb_vld, pipe_empty;
   logic [IW-1:0]            wb_idx;
   logic [RND_W-1:0]         rnd_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      issue          = 1'b0;
      sbif.rnd_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ISSUE;
               idx_d   = '0;
            end
         end
         ST_ISSUE: begin
            sbif.rnd_ready = 1'b1;
            if (sbif.rnd_valid) begin
               issue = 1'b1;
               if (idx_q == LAST) state_d = ST_DRAIN;
               else               idx_d   = idx_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Issue order is strictly ascending, so writeback only touches already-issued bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bufa_q <= '0;
         bufm_q <= '0;
      end else if (state_q == ST_IDLE && start) begin
         bufa_q <= st_in_a;
         bufm_q <= st_in_m;
      end else begin
         if (wb_vld) begin
            bufa_q[wb_idx] <= sbif.sb_ra;
            bufm_q[wb_idx] <= sbif.sb_rm;
         end
`ifdef MASKED_SBOX_SEQ_ZEROIZE_EN
         if (state_q == ST_DONE) begin
            bufa_q <= '0;
            bufm_q <= '0;
         end
`endif
      end
   end

   masked_sbox_vpipe #(
      .LAT (LAT),
      .IW  (IW)
   ) u_vpipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (issue),
      .idx_i    (idx_q),
      .wb_vld_o (wb_vld),
      .wb_idx_o (wb_idx),
      .empty_o  (pipe_empty)
   );

   assign rnd_in      = sbif.rnd_data;
   assign sbif.sb_vld = issue;
`ifdef MASKED_SBOX_SEQ_ZEROIZE_EN
   assign sbif.sb_a   = issue ? bufa_q[idx_q] : 8'h00;
   assign sbif.sb_m   = issue ? bufm_q[idx_q] : 8'h00;
   assign sbif.sb_rnd = issue ? rnd_in : '0;
`else
   assign sbif.sb_a   = bufa_q[idx_q];
   assign sbif.sb_m   = bufm_q[idx_q];
   assign sbif.sb_rnd = rnd_in;
`endif

   assign st_out_a = bufa_q;
   assign st_out_m = bufm_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_masked_sbox_seq.sv
// Directed bench for masked_sbox_seq with a behavioural masked S-box datapath and scoreboard.
module tb_masked_sbox_seq;

   localparam int NB = 16;
   localparam int RW = 18;
   parameter  int LAT = 2;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [8*NB-1:0]  st_in_a = '0, st_in_m = '0;
   logic [8*NB-1:0]  st_out_a, st_out_m;
   logic             busy, done;
   int               checks = 0;
   int               failures = 0;

   logic [7:0]       exp_q [$];
   logic [15:0]      iss_q [$];
   logic [7:0]       ra_p [1:LAT];
   logic [7:0]       rm_p [1:LAT];

   masked_sbox_seq_if #(.RND_W(RW)) sbif ();

   masked_sbox_seq #(.NBYTES(NB), .LAT(LAT), .RND_W(RW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .st_in_a  (st_in_a),
      .st_in_m  (st_in_m),
      .st_out_a (st_out_a),
      .st_out_m (st_out_m),
      .busy     (busy),
      .done     (done),
      .sbif     (sbif.master)
   );

   always #5 clk = ~clk;

   // Remasked S-box: out share M is fresh mask from rnd, share A = S(a^m)^mask.
   always @(posedge clk) begin
      if (sbif.sb_vld) begin
         ra_p[1] <= SBOX[sbif.sb_a ^ sbif.sb_m] ^ (sbif.sb_rnd[7:0] ^ sbif.sb_rnd[17:10]);
         rm_p[1] <= sbif.sb_rnd[7:0] ^ sbif.sb_rnd[17:10];
      end else begin
         ra_p[1] <= 8'($urandom);
         rm_p[1] <= 8'($urandom);
      end
      for (int k = 2; k <= LAT; k++) begin
         ra_p[k] <= ra_p[k-1];
         rm_p[k] <= rm_p[k-1];
      end
   end
   assign sbif.sb_ra = ra_p[LAT];
   assign sbif.sb_rm = rm_p[LAT];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_job(input logic [8*NB-1:0] a, input logic [8*NB-1:0] m,
                          input bit stall, input int restart_cyc, input int rst_at);
      int          cyc, ndrv, last_iss, n_hs, n_done, done_cyc;
      bit          hs_exp;
      logic [7:0]  exp_b [NB];
      for (int i = 0; i < NB; i++) begin
         exp_q.push_back(SBOX[a[8*i +: 8] ^ m[8*i +: 8]]);
         iss_q.push_back({a[8*i +: 8], m[8*i +: 8]});
      end
      st_in_a = a; st_in_m = m; start = 1'b1;
      sbif.rnd_valid = 1'b1; sbif.rnd_data = RW'($urandom);
      #1;
      chk("busy_at_start", busy, 1'b0);
      chk("vld_at_start", sbif.sb_vld, 1'b0);
      cyc = 0; ndrv = 0; last_iss = -1; n_hs = 0; n_done = 0; done_cyc = -1;
      while (cyc < 300) begin
         @(posedge clk); @(negedge clk);
         cyc++;
         start = (cyc == restart_cyc);
         if (start) begin st_in_a = ~a; st_in_m = ~m; end
         sbif.rnd_valid = stall ? cyc[0] : 1'b1;
         sbif.rnd_data  = RW'($urandom);
         hs_exp = sbif.rnd_valid && (ndrv < NB);
         if (hs_exp) begin
            ndrv++;
            if (ndrv == NB) last_iss = cyc;
         end
         #1;
         if (cyc == 1) chk("busy_cycle1", busy, 1'b1);
         chk("sb_vld_hs", sbif.sb_vld, hs_exp);
         if (sbif.sb_vld) begin
            n_hs++;
            if (iss_q.size() > 0) begin
               logic [15:0] e;
               e = iss_q.pop_front();
               chk("issue_a", sbif.sb_a, e[15:8]);
               chk("issue_m", sbif.sb_m, e[7:0]);
            end
            chk("issue_rnd", sbif.sb_rnd, sbif.rnd_data);
         end
`ifdef MASKED_SBOX_SEQ_ZEROIZE_EN
         else begin
            chk("zero_bubble_a", sbif.sb_a, 8'h00);
            chk("zero_bubble_m", sbif.sb_m, 8'h00);
            chk("zero_bubble_rnd", sbif.sb_rnd, '0);
         end
`endif
         if (rst_at > 0 && n_hs == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_ready", sbif.rnd_ready, 1'b0);
            chk("rst_vld", sbif.sb_vld, 1'b0);
            chk("rst_sb_a", sbif.sb_a, 8'h00);
            chk("rst_sb_m", sbif.sb_m, 8'h00);
            chk("rst_out_a", st_out_a, '0);
            chk("rst_out_m", st_out_m, '0);
            exp_q.delete(); iss_q.delete();
            start = 1'b0;
            @(negedge clk); @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               chk("done_latency", 32'(cyc), 32'(last_iss + LAT + 1));
               for (int i = 0; i < NB; i++) begin
                  exp_b[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                  chk($sformatf("byte%0d", i), st_out_a[8*i +: 8] ^ st_out_m[8*i +: 8], exp_b[i]);
               end
            end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            chk("done_pulse", done, 1'b0);
            chk("busy_after", busy, 1'b0);
`ifdef MASKED_SBOX_SEQ_ZEROIZE_EN
            chk("zeroize_a", st_out_a, '0);
            chk("zeroize_m", st_out_m, '0);
`else
            for (int i = 0; i < NB; i++)
               chk($sformatf("retain%0d", i), st_out_a[8*i +: 8] ^ st_out_m[8*i +: 8], exp_b[i]);
`endif
         end
         if (done_cyc >= 0 && cyc == done_cyc + 3) break;
      end
      chk("done_seen", done_cyc >= 0, 1'b1);
      chk("handshakes", 32'(n_hs), 32'(NB));
      chk("done_count", 32'(n_done), 32'd1);
      start = 1'b0;
   endtask

   initial begin
      logic [8*NB-1:0] a0, m0, ar, mr;
      sbif.rnd_valid = 1'b0;
      sbif.rnd_data  = '0;
      for (int i = 0; i < NB; i++) begin
         a0[8*i +: 8] = 8'(i);
         m0[8*i +: 8] = 8'h5a;
      end
      repeat (2) @(negedge clk);
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_ready", sbif.rnd_ready, 1'b0);
      chk("reset_vld", sbif.sb_vld, 1'b0);
      chk("reset_sb_a", sbif.sb_a, 8'h00);
      chk("reset_sb_m", sbif.sb_m, 8'h00);
      chk("reset_out_a", st_out_a, '0);
      chk("reset_out_m", st_out_m, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_job(a0, m0, 1'b0, 0, 0);
      chk("byte0_sbox", SBOX[8'h5a], 8'hbe);
      @(negedge clk);
      run_job(a0, m0, 1'b1, 0, 0);
      @(negedge clk);
      run_job(a0, m0, 1'b0, 5, 0);
      @(negedge clk);
      for (int i = 0; i < NB; i++) begin
         ar[8*i +: 8] = 8'($urandom);
         mr[8*i +: 8] = 8'($urandom);
      end
      run_job(ar, mr, 1'b0, 0, 7);
      run_job(ar, mr, 1'b0, 0, 0);
      @(negedge clk);
      run_job(mr, ar, 1'b1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
